// File: rtl/jump_physics_ctl.sv
// Tick-based player motion controller: walking on the floor, charged jump,
// ballistic flight under gravity, side-wall bounce, ceiling stop and landing.
// Position, velocity and charge update only on the physics tick cycle; all
// outputs come straight from registers.
module jump_physics_ctl #(
   parameter int CLOCKS_PER_TICK = 400_000,
   parameter int SCREEN_W        = 800,
   parameter int SCREEN_H        = 600,
   parameter int RECT_W          = 64,
   parameter int RECT_H          = 64,
   parameter int GRAVITY         = 1,
   parameter int VY_MAX          = 16,
   parameter int WALK_VX         = 2,
   parameter int JUMP_VX         = 4,
   parameter int JUMP_BASE       = 4,
   parameter int MAX_CHARGE      = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_space,
   input  logic        key_right,
   input  logic        key_left,
   output logic [11:0] value_x,
   output logic [11:0] value_y,
   output logic        on_ground,
   output logic [5:0]  charge_level
);

   localparam int CNT_W = (CLOCKS_PER_TICK > 2) ? $clog2(CLOCKS_PER_TICK) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_TICK - 1);

   localparam logic signed [12:0] FLOOR_S     = 13'(SCREEN_H - RECT_H);
   localparam logic signed [12:0] X_MAX_S     = 13'(SCREEN_W - RECT_W);
   localparam logic [11:0]        FLOOR_U     = 12'(SCREEN_H - RECT_H);
   localparam logic [11:0]        X_MAX_U     = 12'(SCREEN_W - RECT_W);
   localparam logic [11:0]        X_INIT_U    = 12'((SCREEN_W - RECT_W) / 2);
   localparam logic signed [12:0] GRAV_S      = 13'(GRAVITY);
   localparam logic signed [12:0] VY_MAX_S    = 13'(VY_MAX);
   localparam logic signed [12:0] WALK_S      = 13'(WALK_VX);
   localparam logic signed [12:0] JUMP_VX_S   = 13'(JUMP_VX);
   localparam logic signed [12:0] JUMP_BASE_S = 13'(JUMP_BASE);
   localparam logic [5:0]         MAX_CHG_U   = 6'(MAX_CHARGE);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_CHARGE = 2'd1,
      ST_AIR    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_W-1:0]   r_tick_cnt;
   logic               r_space_prev;
   logic               r_edge_pend;
   logic [11:0]        r_x;
   logic [11:0]        r_y;
   logic signed [12:0] r_vx;
   logic signed [12:0] r_vy;
   logic [5:0]         r_charge;
   logic               r_on_ground;

   logic               w_tick;
   logic               w_space_edge;
   logic               w_right_only;
   logic               w_left_only;
   logic signed [12:0] w_x_s;
   logic signed [12:0] w_y_s;
   logic signed [12:0] w_xn;
   logic signed [12:0] w_yn;

   logic               w_edge_pend_nxt;
   logic [11:0]        w_x_nxt;
   logic [11:0]        w_y_nxt;
   logic signed [12:0] w_vx_nxt;
   logic signed [12:0] w_vy_nxt;
   logic [5:0]         w_charge_nxt;

   // Charge increments by one per held tick and sticks at the ceiling value.
   function automatic logic [5:0] sat_charge(input logic [5:0] c);
      return (c >= MAX_CHG_U) ? MAX_CHG_U : c + 6'd1;
   endfunction

   // Gravity-accelerated vertical speed, capped at terminal fall speed.
   function automatic logic signed [12:0] clamp_vy(input logic signed [12:0] v);
      logic signed [12:0] s;
      s = v + GRAV_S;
      return (s > VY_MAX_S) ? VY_MAX_S : s;
   endfunction

   // Walking position limited to the visible horizontal range.
   function automatic logic [11:0] clamp_x(input logic signed [12:0] xn);
      if (xn < 13'sd0)
         return 12'd0;
      else if (xn > X_MAX_S)
         return X_MAX_U;
      else
         return xn[11:0];
   endfunction

   assign w_tick       = (r_tick_cnt == CNT_MAX);
   assign w_space_edge = key_space & ~r_space_prev;
   assign w_right_only = key_right & ~key_left;
   assign w_left_only  = key_left & ~key_right;
   assign w_x_s        = $signed({1'b0, r_x});
   assign w_y_s        = $signed({1'b0, r_y});
   assign w_xn         = w_x_s + r_vx;
   assign w_yn         = w_y_s + r_vy;

   // Free-running physics tick divider.
   always_ff @(posedge clk) begin
      if (rst)
         r_tick_cnt <= '0;
      else if (w_tick)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_GROUND;
      else
         r_state <= w_state_nxt;
   end

   // Next-state and motion update; edge_pend only lives while on the ground.
   always_comb begin
      w_state_nxt     = r_state;
      w_edge_pend_nxt = 1'b0;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_vx_nxt        = r_vx;
      w_vy_nxt        = r_vy;
      w_charge_nxt    = r_charge;
      case (r_state)
         ST_GROUND: begin
            w_edge_pend_nxt = r_edge_pend | w_space_edge;
            if (w_tick) begin
               if (r_edge_pend | w_space_edge) begin
                  w_state_nxt     = ST_CHARGE;
                  w_charge_nxt    = 6'd0;
                  w_edge_pend_nxt = 1'b0;
               end else if (w_right_only) begin
                  w_x_nxt = clamp_x(w_x_s + WALK_S);
               end else if (w_left_only) begin
                  w_x_nxt = clamp_x(w_x_s - WALK_S);
               end
            end
         end
         ST_CHARGE: begin
            if (w_tick) begin
               if (key_space) begin
                  w_charge_nxt = sat_charge(r_charge);
               end else begin
                  w_vy_nxt     = -(JUMP_BASE_S + $signed({7'd0, r_charge}));
                  w_vx_nxt     = w_right_only ? JUMP_VX_S :
                                 w_left_only  ? -JUMP_VX_S : 13'sd0;
                  w_charge_nxt = 6'd0;
                  w_state_nxt  = ST_AIR;
               end
            end
         end
         ST_AIR: begin
            if (w_tick) begin
               w_vy_nxt = clamp_vy(r_vy);
               if (w_xn < 13'sd0) begin
                  w_x_nxt  = 12'd0;
                  w_vx_nxt = -r_vx;
               end else if (w_xn > X_MAX_S) begin
                  w_x_nxt  = X_MAX_U;
                  w_vx_nxt = -r_vx;
               end else begin
                  w_x_nxt = w_xn[11:0];
               end
               if (w_yn >= FLOOR_S) begin
                  w_y_nxt     = FLOOR_U;
                  w_vx_nxt    = 13'sd0;
                  w_vy_nxt    = 13'sd0;
                  w_state_nxt = ST_GROUND;
               end else if (w_yn < 13'sd0) begin
                  w_y_nxt  = 12'd0;
                  w_vy_nxt = 13'sd0;
               end else begin
                  w_y_nxt = w_yn[11:0];
               end
            end
         end
         default: begin
            w_state_nxt = ST_GROUND;
         end
      endcase
   end

   // Motion, charge and key-tracking registers; reset wins over any flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x          <= X_INIT_U;
         r_y          <= FLOOR_U;
         r_vx         <= 13'sd0;
         r_vy         <= 13'sd0;
         r_charge     <= 6'd0;
         r_space_prev <= 1'b0;
         r_edge_pend  <= 1'b0;
         r_on_ground  <= 1'b1;
      end else begin
         r_x          <= w_x_nxt;
         r_y          <= w_y_nxt;
         r_vx         <= w_vx_nxt;
         r_vy         <= w_vy_nxt;
         r_charge     <= w_charge_nxt;
         r_space_prev <= key_space;
         r_edge_pend  <= w_edge_pend_nxt;
         r_on_ground  <= (w_state_nxt != ST_AIR);
      end
   end

   assign value_x      = r_x;
   assign value_y      = r_y;
   assign on_ground    = r_on_ground;
   assign charge_level = r_charge;

endmodule

// File: tb/tb_jump_physics_ctl.sv
// Bench for jump_physics_ctl: directed scenarios plus randomized key traffic,
// checked against an integer-arithmetic motion model kept in the bench.
module tb_jump_physics_ctl;

   localparam int CPT   = 4;
   localparam int FLOOR = 536;
   localparam int XMAX  = 736;
   localparam int XINIT = 368;
   localparam int MG    = 0;
   localparam int MC    = 1;
   localparam int MA    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_space;
   logic        key_right;
   logic        key_left;
   logic [11:0] value_x;
   logic [11:0] value_y;
   logic        on_ground;
   logic [5:0]  charge_level;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   int m_x, m_y, m_vx, m_vy, m_chg, m_mode, m_cnt;
   bit m_pend, m_sp_prev, m_ticked;

   jump_physics_ctl #(.CLOCKS_PER_TICK(CPT)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_space    (key_space),
      .key_right    (key_right),
      .key_left     (key_left),
      .value_x      (value_x),
      .value_y      (value_y),
      .on_ground    (on_ground),
      .charge_level (charge_level)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_x = XINIT; m_y = FLOOR; m_vx = 0; m_vy = 0; m_chg = 0;
      m_mode = MG; m_cnt = 0; m_pend = 0; m_sp_prev = 0; m_ticked = 0;
   endfunction

   function automatic void model_clock();
      bit tick, edge_s, r_only, l_only;
      int xn, yn, vy2;
      if (rst) begin
         model_reset();
         return;
      end
      tick   = (m_cnt == CPT - 1);
      edge_s = key_space && !m_sp_prev;
      r_only = key_right && !key_left;
      l_only = key_left && !key_right;
      if (m_mode == MG) begin
         m_pend = m_pend || edge_s;
         if (tick) begin
            if (m_pend) begin
               m_mode = MC; m_chg = 0; m_pend = 0;
            end else if (r_only) begin
               m_x = (m_x + 2 > XMAX) ? XMAX : m_x + 2;
            end else if (l_only) begin
               m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
            end
         end
      end else if (m_mode == MC) begin
         m_pend = 0;
         if (tick) begin
            if (key_space) begin
               m_chg = (m_chg + 1 > 31) ? 31 : m_chg + 1;
            end else begin
               m_vy = -(4 + m_chg);
               m_vx = r_only ? 4 : (l_only ? -4 : 0);
               m_chg = 0;
               m_mode = MA;
            end
         end
      end else begin
         m_pend = 0;
         if (tick) begin
            yn  = m_y + m_vy;
            vy2 = (m_vy + 1 > 16) ? 16 : m_vy + 1;
            xn  = m_x + m_vx;
            if (xn < 0) begin
               m_x = 0; m_vx = -m_vx;
            end else if (xn > XMAX) begin
               m_x = XMAX; m_vx = -m_vx;
            end else begin
               m_x = xn;
            end
            if (yn >= FLOOR) begin
               m_y = FLOOR; m_vx = 0; m_vy = 0; m_mode = MG;
            end else if (yn < 0) begin
               m_y = 0; m_vy = 0;
            end else begin
               m_y = yn; m_vy = vy2;
            end
         end
      end
      m_sp_prev = key_space;
      m_cnt     = tick ? 0 : m_cnt + 1;
      m_ticked  = tick;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic adv_tick();
      do cycle(); while (!m_ticked);
   endtask

   task automatic test_reset();
      rst = 1'b1; key_space = 1'b0; key_right = 1'b0; key_left = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      n_vec++;
      if (value_x !== 12'd368) begin
         n_err++; $display("FAIL reset_x got %0d want 368", value_x);
      end
      n_vec++;
      if (value_y !== 12'd536) begin
         n_err++; $display("FAIL reset_y got %0d want 536", value_y);
      end
      n_vec++;
      if (on_ground !== 1'b1 || charge_level !== 6'd0) begin
         n_err++; $display("FAIL reset_status got g=%0b c=%0d want g=1 c=0", on_ground, charge_level);
      end
   endtask

   task automatic test_walk();
      key_right = 1'b1;
      for (int i = 0; i < 10; i++) begin
         adv_tick();
         n_vec++;
         if (value_x !== 12'(m_x) || value_y !== 12'(m_y) || on_ground !== (m_mode != MA)) begin
            n_err++; $display("FAIL walk_right x=%0d/%0d y=%0d/%0d", value_x, m_x, value_y, m_y);
         end
      end
      n_vec++;
      if (value_x !== 12'd388) begin
         n_err++; $display("FAIL walk_right_10 got %0d want 388", value_x);
      end
      key_left = 1'b1;
      for (int i = 0; i < 5; i++) adv_tick();
      n_vec++;
      if (value_x !== 12'd388) begin
         n_err++; $display("FAIL walk_both got %0d want 388", value_x);
      end
      key_right = 1'b0;
      for (int i = 0; i < 200; i++) begin
         adv_tick();
         n_vec++;
         if (value_x !== 12'(m_x)) begin
            n_err++; $display("FAIL walk_left x=%0d want %0d", value_x, m_x);
         end
      end
      n_vec++;
      if (value_x !== 12'd0) begin
         n_err++; $display("FAIL walk_left_wall got %0d want 0", value_x);
      end
      key_left = 1'b0;
   endtask

   task automatic test_charged_jump();
      int exp_y [15] = '{529, 523, 518, 514, 511, 509, 508, 508, 509, 511, 514, 518, 523, 529, 536};
      key_space = 1'b1;
      adv_tick();
      n_vec++;
      if (on_ground !== 1'b1 || charge_level !== 6'd0 || value_y !== 12'd536) begin
         n_err++; $display("FAIL charge_enter g=%0b c=%0d y=%0d want 1 0 536", on_ground, charge_level, value_y);
      end
      for (int i = 1; i <= 3; i++) begin
         adv_tick();
         n_vec++;
         if (charge_level !== 6'(i)) begin
            n_err++; $display("FAIL charge_count got %0d want %0d", charge_level, i);
         end
      end
      key_space = 1'b0;
      adv_tick();
      n_vec++;
      if (on_ground !== 1'b0 || charge_level !== 6'd0 || value_y !== 12'd536 || m_vy != -7) begin
         n_err++; $display("FAIL launch g=%0b c=%0d y=%0d model_vy=%0d want 0 0 536 -7", on_ground, charge_level, value_y, m_vy);
      end
      for (int i = 0; i < 15; i++) begin
         adv_tick();
         n_vec++;
         if (value_y !== 12'(exp_y[i])) begin
            n_err++; $display("FAIL jump_y tick %0d got %0d want %0d", i, value_y, exp_y[i]);
         end
      end
      n_vec++;
      if (on_ground !== 1'b1) begin
         n_err++; $display("FAIL jump_land got %0b want 1", on_ground);
      end
   endtask

   task automatic test_max_charge();
      int guard, prev_y, max_dy;
      bit saw_ceiling;
      key_space = 1'b1;
      adv_tick();
      for (int i = 0; i < 100; i++) adv_tick();
      n_vec++;
      if (charge_level !== 6'd31) begin
         n_err++; $display("FAIL charge_sat got %0d want 31", charge_level);
      end
      key_space = 1'b0;
      adv_tick();
      n_vec++;
      if (m_vy != -35 || on_ground !== 1'b0) begin
         n_err++; $display("FAIL max_launch model_vy=%0d g=%0b want -35 0", m_vy, on_ground);
      end
      guard = 0; saw_ceiling = 0; max_dy = 0; prev_y = int'(value_y);
      do begin
         adv_tick();
         guard++;
         n_vec++;
         if (value_x !== 12'(m_x) || value_y !== 12'(m_y) || on_ground !== (m_mode != MA)) begin
            n_err++; $display("FAIL max_flight x=%0d/%0d y=%0d/%0d g=%0b", value_x, m_x, value_y, m_y, on_ground);
         end
         if (value_y == 12'd0) saw_ceiling = 1;
         if (int'(value_y) - prev_y > max_dy) max_dy = int'(value_y) - prev_y;
         prev_y = int'(value_y);
      end while (on_ground !== 1'b1 && guard < 200);
      n_vec++;
      if (guard >= 200) begin
         n_err++; $display("FAIL max_flight_timeout ticks=%0d limit 200", guard);
      end
      n_vec++;
      if (!saw_ceiling) begin
         n_err++; $display("FAIL ceiling_hit got none want y=0");
      end
      n_vec++;
      if (max_dy != 16) begin
         n_err++; $display("FAIL fall_cap got %0d want 16", max_dy);
      end
      n_vec++;
      if (value_y !== 12'd536) begin
         n_err++; $display("FAIL max_land got %0d want 536", value_y);
      end
   endtask

   task automatic test_wall_bounce();
      int guard;
      int exp_x [4] = '{734, 736, 732, 728};
      key_right = 1'b1;
      guard = 0;
      while (m_x != 730 && guard < 500) begin
         adv_tick();
         guard++;
      end
      n_vec++;
      if (value_x !== 12'd730) begin
         n_err++; $display("FAIL walk_to_730 got %0d want 730", value_x);
      end
      key_right = 1'b0; key_space = 1'b1;
      adv_tick();
      key_space = 1'b0; key_right = 1'b1;
      adv_tick();
      n_vec++;
      if (value_x !== 12'd730 || on_ground !== 1'b0) begin
         n_err++; $display("FAIL bounce_launch x=%0d g=%0b want 730 0", value_x, on_ground);
      end
      for (int i = 0; i < 4; i++) begin
         adv_tick();
         n_vec++;
         if (value_x !== 12'(exp_x[i]) || value_y !== 12'(m_y)) begin
            n_err++; $display("FAIL bounce_x tick %0d x=%0d want %0d y=%0d want %0d", i, value_x, exp_x[i], value_y, m_y);
         end
      end
      key_right = 1'b0;
   endtask

   task automatic test_reset_mid_air();
      cycle();
      cycle();
      n_vec++;
      if (on_ground !== 1'b0) begin
         n_err++; $display("FAIL pre_reset_air got g=%0b want 0", on_ground);
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      n_vec++;
      if (value_x !== 12'd368 || value_y !== 12'd536 || on_ground !== 1'b1 || charge_level !== 6'd0) begin
         n_err++; $display("FAIL mid_air_reset x=%0d y=%0d g=%0b c=%0d want 368 536 1 0", value_x, value_y, on_ground, charge_level);
      end
      key_right = 1'b1;
      adv_tick();
      key_right = 1'b0;
      n_vec++;
      if (value_x !== 12'd370 || value_y !== 12'd536) begin
         n_err++; $display("FAIL post_reset_walk x=%0d y=%0d want 370 536", value_x, value_y);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            key_right = 1'($urandom_range(0, 1));
            key_left  = 1'($urandom_range(0, 1));
            if (m_mode == MG)
               key_space = 1'($urandom_range(0, 1));
            else
               key_space = key_space & 1'($urandom_range(0, 1));
         end
         rst = ($urandom_range(0, 499) == 0);
         cycle();
         n_vec++;
         if (value_x !== 12'(m_x) || value_y !== 12'(m_y) || on_ground !== (m_mode != MA) ||
             charge_level !== 6'(m_chg)) begin
            n_err++;
            $display("FAIL random cyc %0d x=%0d/%0d y=%0d/%0d g=%0b/%0b c=%0d/%0d", i, value_x, m_x,
                     value_y, m_y, on_ground, (m_mode != MA), charge_level, m_chg);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; key_space = 1'b0; key_right = 1'b0; key_left = 1'b0;
      model_reset();
      test_reset();
      test_walk();
      test_charged_jump();
      test_max_charge();
      test_wall_bounce();
      test_reset_mid_air();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
